// File: rtl/sonar_capture_sequencer.sv
// ---------------------------------------------------------------------------
// sonar_capture_sequencer
//
// Sequences ADC sample capture into a ping-pong (dual-bank) sample RAM that
// feeds the LCD trace renderer. One bank is filled while the display reads
// the other. Banks swap only on a display frame boundary, so the renderer
// never reads the bank being written. A hysteretic rising-edge trigger is
// searched for in every capture and its position is published with the
// read bank.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           synchronous reset, active-high
//   sample_valid  one-cycle strobe, new ADC sample present
//   sample        unsigned ADC sample, valid with sample_valid
//   frame_start   one-cycle pulse at display frame start
//   wr_en         RAM write enable (one cycle after an accepted strobe)
//   wr_addr       {write bank, in-bank address}
//   wr_data       RAM write data
//   rd_bank       bank the display reads (complement of the write bank)
//   trig_pos      trigger address inside the rd_bank capture
//   trig_found    1 = trig_pos is a real trigger, 0 = default PRETRIG
//   drop_cnt      saturating count of samples dropped while awaiting a swap
// ---------------------------------------------------------------------------
module sonar_capture_sequencer #(
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned PRETRIG = 400,
   parameter int unsigned THRESH  = 128,
   parameter int unsigned HYST    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   input  logic              frame_start,
   output logic              wr_en,
   output logic [ADDR_W:0]   wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_bank,
   output logic [ADDR_W-1:0] trig_pos,
   output logic              trig_found,
   output logic [7:0]        drop_cnt
);

   // One extra bit so THRESH may equal 2^DATA_W without wrapping.
   localparam int unsigned CMP_W   = DATA_W + 1;
   // Re-arm level saturates at zero when HYST exceeds THRESH.
   localparam int unsigned ARM_LVL = (THRESH > HYST) ? (THRESH - HYST) : 0;

   localparam logic [CMP_W-1:0]  THRESH_C  = CMP_W'(THRESH);
   localparam logic [CMP_W-1:0]  ARM_C     = CMP_W'(ARM_LVL);
   localparam logic [ADDR_W-1:0] PRETRIG_A = ADDR_W'(PRETRIG);
   localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
   localparam logic [7:0]        DROP_MAX  = 8'hFF;

   typedef enum logic {
      S_FILL,
      S_WAIT
   } state_t;

   state_t              state_q, state_n;
   logic                wbank_q, wbank_n;
   logic [ADDR_W-1:0]   addr_q, addr_n;
   logic                armed_q, armed_n;
   logic                pend_found_q, pend_found_n;
   logic [ADDR_W-1:0]   pend_pos_q, pend_pos_n;

   logic                wr_en_n;
   logic [ADDR_W:0]     wr_addr_n;
   logic [DATA_W-1:0]   wr_data_n;
   logic                rd_bank_n;
   logic [ADDR_W-1:0]   trig_pos_n;
   logic                trig_found_n;
   logic [7:0]          drop_cnt_n;

   logic [CMP_W-1:0]    samp_ext;

   assign samp_ext = {1'b0, sample};

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FILL;
         wbank_q      <= 1'b0;
         addr_q       <= '0;
         armed_q      <= 1'b0;
         pend_found_q <= 1'b0;
         pend_pos_q   <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         rd_bank      <= 1'b1;
         trig_pos     <= PRETRIG_A;
         trig_found   <= 1'b0;
         drop_cnt     <= 8'd0;
      end else begin
         state_q      <= state_n;
         wbank_q      <= wbank_n;
         addr_q       <= addr_n;
         armed_q      <= armed_n;
         pend_found_q <= pend_found_n;
         pend_pos_q   <= pend_pos_n;
         wr_en        <= wr_en_n;
         wr_addr      <= wr_addr_n;
         wr_data      <= wr_data_n;
         rd_bank      <= rd_bank_n;
         trig_pos     <= trig_pos_n;
         trig_found   <= trig_found_n;
         drop_cnt     <= drop_cnt_n;
      end
   end

   // Next-state, capture, trigger search and bank swap.
   always_comb begin
      state_n      = state_q;
      wbank_n      = wbank_q;
      addr_n       = addr_q;
      armed_n      = armed_q;
      pend_found_n = pend_found_q;
      pend_pos_n   = pend_pos_q;
      wr_en_n      = 1'b0;
      wr_addr_n    = wr_addr;
      wr_data_n    = wr_data;
      rd_bank_n    = rd_bank;
      trig_pos_n   = trig_pos;
      trig_found_n = trig_found;
      drop_cnt_n   = drop_cnt;

      case (state_q)
         S_FILL: begin
            // frame_start is deliberately ignored while filling.
            if (sample_valid) begin
               wr_en_n   = 1'b1;
               wr_addr_n = {wbank_q, addr_q};
               wr_data_n = sample;

               // Address parks at the top of the bank until the swap.
               if (addr_q == ADDR_MAX) begin
                  state_n = S_WAIT;
               end else begin
                  addr_n = addr_q + ADDR_W'(1);
               end

               // Hysteretic edge: low sample arms, armed crossing fires.
               // A crossing before PRETRIG still consumes the arm.
               if (samp_ext < ARM_C) begin
                  armed_n = 1'b1;
               end else if (armed_q && (samp_ext >= THRESH_C)) begin
                  armed_n = 1'b0;
                  if ((addr_q >= PRETRIG_A) && !pend_found_q) begin
                     pend_found_n = 1'b1;
                     pend_pos_n   = addr_q;
                  end
               end
            end
         end

         S_WAIT: begin
            if (frame_start) begin
               // Swap: publish the finished bank and its trigger. A
               // coincident strobe is dropped without being counted.
               wbank_n      = ~wbank_q;
               rd_bank_n    = wbank_q;
               trig_pos_n   = pend_found_q ? pend_pos_q : PRETRIG_A;
               trig_found_n = pend_found_q;
               pend_found_n = 1'b0;
               armed_n      = 1'b0;
               addr_n       = '0;
               drop_cnt_n   = 8'd0;
               state_n      = S_FILL;
            end else if (sample_valid && (drop_cnt != DROP_MAX)) begin
               drop_cnt_n = drop_cnt + 8'd1;
            end
         end

         default: begin
            state_n = S_FILL;
         end
      endcase
   end

endmodule

// File: tb/tb_sonar_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sonar_capture_sequencer
//
// Bench for sonar_capture_sequencer (ADDR_W=4, PRETRIG=3) plus a
// default-parameter smoke instance. Expected writes and display updates are
// queued by a capture-level reference model; a negedge monitor pops them.
// ---------------------------------------------------------------------------
module tb_sonar_capture_sequencer;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int PT    = 3;
   localparam int TH    = 128;
   localparam int HY    = 16;
   localparam int DEPTH = 16;

   logic          clk;
   logic          rst;
   logic          sample_valid;
   logic [DW-1:0] sample;
   logic          frame_start;

   logic          wr_en;
   logic [AW:0]   wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_bank;
   logic [AW-1:0] trig_pos;
   logic          trig_found;
   logic [7:0]    drop_cnt;

   logic          d_wr_en;
   logic [11:0]   d_wr_addr;
   logic [7:0]    d_wr_data;
   logic          d_rd_bank;
   logic [10:0]   d_trig_pos;
   logic          d_trig_found;
   logic [7:0]    d_drop_cnt;

   sonar_capture_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .PRETRIG(PT), .THRESH(TH), .HYST(HY)
   ) u_dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
      .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_bank(rd_bank), .trig_pos(trig_pos),
      .trig_found(trig_found), .drop_cnt(drop_cnt)
   );

   sonar_capture_sequencer u_def (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
      .frame_start(frame_start), .wr_en(d_wr_en), .wr_addr(d_wr_addr),
      .wr_data(d_wr_data), .rd_bank(d_rd_bank), .trig_pos(d_trig_pos),
      .trig_found(d_trig_found), .drop_cnt(d_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: capture contents plus bank/position bookkeeping.
   int         m_addr;
   bit         m_bank;
   bit         m_wait;
   int         m_drop;
   int         cap[$];

   logic [12:0] wr_q[$];
   int          wr_due[$];
   logic [5:0]  disp_q[$];
   int          disp_due[$];
   logic [5:0]  mon_disp;
   logic        rst_seen;

   logic [7:0]  pat [DEPTH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // First armed rising edge at or after PT in a finished capture.
   function automatic logic [4:0] find_trig();
      bit armed;
      armed = 1'b0;
      for (int i = 0; i < cap.size(); i++) begin
         if (cap[i] < TH - HY) begin
            armed = 1'b1;
         end else if (armed && cap[i] >= TH) begin
            armed = 1'b0;
            if (i >= PT) return {1'b1, 4'(i)};
         end
      end
      return {1'b0, 4'(PT)};
   endfunction

   task automatic model_apply(input bit r, input bit sv, input logic [7:0] s, input bit fs);
      logic [4:0] t;
      if (r) begin
         m_addr = 0; m_bank = 1'b0; m_wait = 1'b0; m_drop = 0;
         cap.delete();
      end else if (!m_wait) begin
         if (sv) begin
            wr_q.push_back({m_bank, 4'(m_addr), s});
            wr_due.push_back(cyc + 1);
            cap.push_back(int'(s));
            if (m_addr == DEPTH - 1) m_wait = 1'b1;
            else m_addr++;
         end
      end else if (fs) begin
         t = find_trig();
         m_bank = !m_bank;
         disp_q.push_back({!m_bank, t[3:0], t[4]});
         disp_due.push_back(cyc + 1);
         cap.delete();
         m_addr = 0; m_drop = 0; m_wait = 1'b0;
      end else if (sv && m_drop < 255) begin
         m_drop++;
      end
   endtask

   task automatic step(input bit r, input bit sv, input logic [7:0] s, input bit fs);
      @(posedge clk);
      #1;
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      rst          = r;
      sample_valid = sv;
      sample       = s;
      frame_start  = fs;
      model_apply(r, sv, s, fs);
   endtask

   task automatic capture(input int fs_at, input bit swap_sv);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, pat[i], i == fs_at);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, swap_sv, 8'h55, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   function automatic logic [7:0] rnd_sample();
      case ($urandom % 4)
         0:       return 8'($urandom);
         1:       return 8'($urandom_range(100, 127));
         2:       return 8'($urandom_range(128, 140));
         default: return 8'($urandom_range(0, 111));
      endcase
   endfunction

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   // Monitor: reset values, write scoreboard, published display state.
   always @(negedge clk) begin
      logic [12:0] exp_w;
      int          due;
      if (rst_seen) begin
         chk("rst_wr_en", 32'(wr_en), 32'd0);
         chk("rst_wr_addr", 32'(wr_addr), 32'd0);
         chk("rst_display", 32'({rd_bank, trig_pos, trig_found}), 32'({1'b1, 4'(PT), 1'b0}));
         mon_disp = {1'b1, 4'(PT), 1'b0};
      end else begin
         if (wr_en) begin
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL write_unexpected actual addr=%0h data=%0h expected none", wr_addr, wr_data);
            end else begin
               exp_w = wr_q.pop_front();
               due   = wr_due.pop_front();
               chk("write_addr_data", 32'({wr_addr, wr_data}), 32'(exp_w));
               chk("write_cycle", 32'(cyc), 32'(due));
            end
         end
         if (disp_q.size() > 0 && cyc >= disp_due[0]) begin
            mon_disp = disp_q.pop_front();
            due      = disp_due.pop_front();
         end
         chk("display", 32'({rd_bank, trig_pos, trig_found}), 32'(mon_disp));
      end
   end

   initial begin
      rst = 1'b1; sample_valid = 1'b0; sample = '0; frame_start = 1'b0;
      model_apply(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Default-parameter smoke: reset values.
      chk("def_rd_bank", 32'(d_rd_bank), 32'd1);
      chk("def_trig_pos", 32'(d_trig_pos), 32'd400);
      chk("def_trig_found", 32'(d_trig_found), 32'd0);
      chk("def_wr_en", 32'(d_wr_en), 32'd0);

      // Fill bank 0 with zeros.
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("def_last_wr_en", 32'(d_wr_en), 32'd1);
      chk("def_last_wr_addr", 32'(d_wr_addr), 32'h00F);

      // Three drops in WAIT, then swap.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hAA, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Trigger at 5; second edge at 9 ignored.
      for (int i = 0; i < DEPTH; i++) pat[i] = 8'd10;
      pat[5] = 8'd200; pat[9] = 8'd200;
      capture(-1, 1'b0);

      // Edge below PRETRIG consumes the arm; no re-arm afterwards.
      for (int i = 0; i < DEPTH; i++) pat[i] = 8'd150;
      pat[0] = 8'd10; pat[1] = 8'd200;
      capture(-1, 1'b0);
      pat[6] = 8'd100; pat[7] = 8'd130;
      capture(-1, 1'b0);

      // frame_start during FILL ignored; strobe on swap cycle dropped.
      for (int i = 0; i < DEPTH; i++) pat[i] = 8'd50;
      capture(7, 1'b1);

      // Reset mid-capture coincident with a strobe.
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'd10, 1'b0);
      step(1'b1, 1'b1, 8'd200, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("mid_rst_trig_pos", 32'(trig_pos), 32'(PT));

      // drop_cnt saturation.
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, rnd_sample(), 1'b0);
      for (int i = 0; i < 300; i++) step(1'b0, 1'b1, rnd_sample(), 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("drop_saturated", 32'(drop_cnt), 32'd255);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // Randomised traffic.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom % 600) == 0, ($urandom % 4) != 0, rnd_sample(), ($urandom % 25) == 0);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

      chk("writes_drained", 32'(wr_q.size()), 32'd0);
      chk("swaps_drained", 32'(disp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
